result_collector: RTL and testbench
===================================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter NUM_PE, default 4: number of processing-unit result ports.
REQ-002 SHALL have parameter DATA_W, default 16: signed result width (two's complement).
REQ-003 SHALL have parameter CNT_W, default 8: result-count and address-offset width.
REQ-004 m_clk  input  1: single clock; all logic on its rising edge.
REQ-005 rst  input  1: reset, synchronous, active-low.
REQ-006 en  input  1: start request, sampled in IDLE.
REQ-007 layer_index  input  4: layer being collected; latched at start.
REQ-008 p_index_in  input  4: partition index; latched at start.
REQ-009 need_act  input  1: apply ReLU to results; latched at start.
REQ-010 out_count  input  CNT_W: number of results expected; latched at start.
REQ-011 pe_valid  input  NUM_PE: per-PE result valid.
REQ-012 pe_data  input  NUM_PE*DATA_W: PE i result in bits [i*DATA_W +: DATA_W].
REQ-013 pe_ready  output  NUM_PE: one-hot grant; a transfer occurs when pe_valid[i] and pe_ready[i] are both 1.
REQ-014 wr_en  output  1: buffer write strobe.
REQ-015 wr_addr  output  8+CNT_W: write address {layer_index, p_index, offset}.
REQ-016 wr_data  output  DATA_W: write data.
REQ-017 busy  output  1: high in COLLECT.
REQ-018 all_done  output  1: one-cycle pulse when the last result is written.

Function
REQ-019 SHALL implement FSM states IDLE, COLLECT, DONE.
REQ-020 IDLE -> COLLECT when en=1: latch layer_index, p_index_in, need_act, out_count; clear offset counter.
REQ-021 Start with latched out_count=0 SHALL go IDLE -> DONE directly, with no writes.
REQ-022 In COLLECT, grant at most one PE per cycle, round-robin, starting at the index after the last granted PE (PE0 first after reset).
REQ-023 pe_ready SHALL be combinational from pe_valid and the arbitration pointer, and SHALL be zero outside COLLECT.
REQ-024 Each transfer SHALL register wr_en=1, wr_data and wr_addr on the following cycle (1-cycle latency); offset then increments by 1.
REQ-025 On the transfer that makes the accepted count equal out_count, move to DONE; pe_ready is zero from the next cycle.
REQ-026 DONE SHALL last exactly one cycle with all_done=1 (aligned with the final wr_en), then return to IDLE.
REQ-027 en held high in IDLE after DONE SHALL start a new collection.
REQ-028 en SHALL be ignored in COLLECT and DONE.
REQ-029 The offset counter SHALL count to at most 2^CNT_W-1 without wrapping, because out_count bounds it.
REQ-030 No valid PEs in a COLLECT cycle SHALL produce no transfer and no pointer change.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE and set pe_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, all_done=0, offset=0, arbitration pointer=0.
REQ-032 Reset mid-COLLECT SHALL abandon the collection; any transfer in that cycle SHALL NOT be written.

Configuration
REQ-033 With macro COLLECTOR_ACT_EN defined and latched need_act=1, wr_data SHALL be 0 for negative results and the unmodified result otherwise.
REQ-034 Without COLLECTOR_ACT_EN, need_act SHALL be ignored and wr_data SHALL equal the unmodified result.

Verification
REQ-035 rst=0 for 2 cycles, then 1 -> all outputs 0 and state IDLE.
REQ-036 layer_index=2, p_index=1, out_count=4, need_act=0, all four PEs valid with data 10,20,30,40 -> writes 10,20,30,40 at offsets 0..3 with wr_addr high byte 0x21; all_done pulses with the fourth write.
REQ-037 COLLECTOR_ACT_EN defined, need_act=1, PE0 data -5 then 7 -> wr_data 0 then 7; without the macro -> -5 then 7.
REQ-038 out_count=0, en=1 -> all_done pulses the cycle after start; wr_en stays 0.
REQ-039 Only PE2 valid, out_count=3 -> three consecutive grants to PE2; pointer fairness holds once PE0 becomes valid again.
REQ-040 rst=0 after 2 of 4 writes -> no further wr_en; a restart writes from offset 0.

Source files
------------

// File: rtl/result_collector.sv
// Collects PE results via a round-robin one-hot grant and writes them to the layer buffer.
// Optional ReLU on written data is enabled by the COLLECTOR_ACT_EN macro.
module result_collector #(
   parameter int NUM_PE = 4,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic                     m_clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [3:0]               layer_index,
   input  logic [3:0]               p_index_in,
   input  logic                     need_act,
   input  logic [CNT_W-1:0]         out_count,
   input  logic [NUM_PE-1:0]        pe_valid,
   input  logic [NUM_PE*DATA_W-1:0] pe_data,
   output logic [NUM_PE-1:0]        pe_ready,
   output logic                     wr_en,
   output logic [8+CNT_W-1:0]       wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     busy,
   output logic                     all_done
);

   localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [3:0]         layer_q;
   logic [3:0]         pidx_q;
   logic               act_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   offset;
   logic [PTR_W-1:0]   ptr;

   logic [NUM_PE-1:0]  grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               grant_any;
   logic               last_xfer;
   logic [PTR_W:0]     scan_sum;
   logic [PTR_W-1:0]   scan_idx;

   logic [DATA_W-1:0]  pe_word [NUM_PE];
   logic [DATA_W-1:0]  sel_data;
   logic [DATA_W-1:0]  out_data;

   always_comb begin
      for (int i = 0; i < NUM_PE; i++) begin
         pe_word[i] = pe_data[i*DATA_W +: DATA_W];
      end
   end

   // Scan from the pointer (the PE after the last grant); first valid PE wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      scan_sum  = '0;
      scan_idx  = '0;
      if (state == COLLECT) begin
         for (int k = 0; k < NUM_PE; k++) begin
            scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_PE)) begin
               scan_sum = scan_sum - (PTR_W+1)'(NUM_PE);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_any && pe_valid[scan_idx]) begin
               grant[scan_idx] = 1'b1;
               grant_idx       = scan_idx;
               grant_any       = 1'b1;
            end
         end
      end
   end

   assign pe_ready  = grant;
   assign sel_data  = pe_word[grant_idx];
   assign last_xfer = grant_any && (({1'b0, offset} + 1'b1) == {1'b0, cnt_q});

`ifdef COLLECTOR_ACT_EN
   assign out_data = (act_q && sel_data[DATA_W-1]) ? '0 : sel_data;
`else
   logic unused_act;
   assign unused_act = act_q;
   assign out_data   = sel_data;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = (out_count == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (last_xfer) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge m_clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge m_clk) begin
      if (!rst) begin
         layer_q  <= '0;
         pidx_q   <= '0;
         act_q    <= 1'b0;
         cnt_q    <= '0;
         offset   <= '0;
         ptr      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         all_done <= 1'b0;
      end else begin
         wr_en    <= grant_any;
         // Registered into DONE so the pulse lines up with the final write.
         all_done <= (state_nxt == DONE);
         if (state == IDLE && en) begin
            layer_q <= layer_index;
            pidx_q  <= p_index_in;
            act_q   <= need_act;
            cnt_q   <= out_count;
            offset  <= '0;
         end
         if (grant_any) begin
            wr_data <= out_data;
            wr_addr <= {layer_q, pidx_q, offset};
            offset  <= offset + 1'b1;
            ptr     <= (grant_idx == PTR_W'(NUM_PE-1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   assign busy = (state == COLLECT);

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: per-cycle reference model, directed tables and sequences, random traffic.
module tb_result_collector;

   logic        m_clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  layer_index = '0;
   logic [3:0]  p_index_in = '0;
   logic        need_act = 1'b0;
   logic [7:0]  out_count = '0;
   logic [3:0]  pe_valid = '0;
   logic [63:0] pe_data = '0;
   logic [3:0]  pe_ready;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        all_done;

   result_collector #(.NUM_PE(4), .DATA_W(16), .CNT_W(8)) dut (
      .m_clk(m_clk), .rst(rst), .en(en), .layer_index(layer_index),
      .p_index_in(p_index_in), .need_act(need_act), .out_count(out_count),
      .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .all_done(all_done)
   );

   always #5 m_clk = ~m_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: mode 0 idle, 1 collecting, 2 finishing.
   int          m_mode = 0;
   int          m_last = 3;
   int          m_acc = 0;
   int          m_cnt = 0;
   logic [3:0]  m_lay = '0;
   logic [3:0]  m_p = '0;
   logic        m_act = 1'b0;
   logic        e_wr_en = 1'b0;
   logic        e_done = 1'b0;
   logic        after_rst = 1'b1;
   logic [15:0] e_wr_data = '0;
   logic [15:0] e_wr_addr = '0;

   logic [15:0] cap_addr [$];
   logic [15:0] cap_data [$];
   logic        cap_done [$];
   int          n_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [3:0] li, input logic [3:0] pi,
                       input logic na, input logic [7:0] oc, input logic [3:0] v, input logic [63:0] d);
      int          gi;
      int          idx;
      logic [3:0]  eg;
      logic [63:0] sh;
      logic [15:0] dat;
      @(negedge m_clk);
      rst = r; en = e; layer_index = li; p_index_in = pi; need_act = na;
      out_count = oc; pe_valid = v; pe_data = d;
      #1;
      gi = -1;
      if (m_mode == 1) begin
         for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (gi < 0 && v[idx[1:0]]) gi = idx;
         end
      end
      eg = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
      chk("pe_ready", 32'(pe_ready), 32'(eg));
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("wr_en", 32'(wr_en), 32'(e_wr_en));
      chk("all_done", 32'(all_done), 32'(e_done));
      if (e_wr_en || after_rst) begin
         chk("wr_data", 32'(wr_data), 32'(e_wr_data));
         chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
      end
      if (wr_en) begin
         cap_addr.push_back(wr_addr);
         cap_data.push_back(wr_data);
         cap_done.push_back(all_done);
      end
      if (all_done) n_done++;
      @(posedge m_clk);
      if (!r) begin
         m_mode = 0; m_last = 3; m_acc = 0;
         e_wr_en = 1'b0; e_done = 1'b0; after_rst = 1'b1;
         e_wr_data = '0; e_wr_addr = '0;
      end else begin
         after_rst = 1'b0; e_wr_en = 1'b0; e_done = 1'b0;
         case (m_mode)
            0: if (e) begin
               m_lay = li; m_p = pi; m_act = na; m_cnt = int'(oc); m_acc = 0;
               m_mode = (oc == 0) ? 2 : 1;
               e_done = (oc == 0);
            end
            1: if (gi >= 0) begin
               sh = d >> (gi * 16);
               dat = sh[15:0];
`ifdef COLLECTOR_ACT_EN
               if (m_act && $signed(dat) < 0) dat = '0;
`endif
               e_wr_en = 1'b1;
               e_wr_data = dat;
               e_wr_addr = {m_lay, m_p, 8'(m_acc)};
               m_acc++;
               m_last = gi;
               if (m_acc == m_cnt) begin
                  m_mode = 2;
                  e_done = 1'b1;
               end
            end
            default: m_mode = 0;
         endcase
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'd0, 64'd0);
   endtask

   task automatic clear_cap();
      cap_addr.delete(); cap_data.delete(); cap_done.delete(); n_done = 0;
   endtask

   typedef struct {
      logic [15:0] din;
      logic [15:0] exp_act;
      logic [15:0] exp_raw;
   } relu_vec_t;

   relu_vec_t   tbl [6];
   logic [63:0] dall;

   initial begin
      tbl[0] = '{16'hFFFB, 16'h0000, 16'hFFFB};
      tbl[1] = '{16'h0007, 16'h0007, 16'h0007};
      tbl[2] = '{16'h0000, 16'h0000, 16'h0000};
      tbl[3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
      tbl[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
      tbl[5] = '{16'h8000, 16'h0000, 16'h8000};

      // Reset for two cycles, then explicit idle-state checks.
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'd0, 64'd0);
      step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 8'd0, 4'hF, 64'd0);
      @(negedge m_clk);
      rst = 1'b1; en = 1'b0; pe_valid = '0;
      #1;
      chk("rst_outputs", {pe_ready, wr_en, busy, all_done}, 32'd0);
      chk("rst_addr_data", {wr_addr, wr_data}, 32'd0);

      // Four PEs, data 10..40, layer 2 partition 1.
      clear_cap();
      dall = {16'd40, 16'd30, 16'd20, 16'd10};
      step(1'b1, 1'b1, 4'd2, 4'd1, 1'b0, 8'd4, 4'h0, dall);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'hF, dall);
      idle(2);
      chk("t4pe_nwr", 32'(cap_data.size()), 32'd4);
      if (cap_data.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t4pe_data", 32'(cap_data[i]), 32'(10 * (i + 1)));
            chk("t4pe_addr", 32'(cap_addr[i]), 32'(16'h2100 + i));
            chk("t4pe_done", 32'(cap_done[i]), 32'(i == 3));
         end
      end

      // ReLU table, one single-result collection per entry.
      foreach (tbl[t]) begin
         clear_cap();
         step(1'b1, 1'b1, 4'd3, 4'd0, 1'b1, 8'd1, 4'h0, 64'd0);
         step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'h1, {48'd0, tbl[t].din});
         idle(2);
         chk("relu_nwr", 32'(cap_data.size()), 32'd1);
         if (cap_data.size() == 1) begin
`ifdef COLLECTOR_ACT_EN
            chk("relu_data", 32'(cap_data[0]), 32'(tbl[t].exp_act));
`else
            chk("relu_data", 32'(cap_data[0]), 32'(tbl[t].exp_raw));
`endif
         end
      end

      // Zero-count start: done pulse, no writes.
      clear_cap();
      step(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 8'd0, 4'hF, 64'd0);
      idle(3);
      chk("zero_nwr", 32'(cap_data.size()), 32'd0);
      chk("zero_ndone", 32'(n_done), 32'd1);

      // Only PE2 valid, then PE0 and PE2 alternate.
      clear_cap();
      dall = {16'd400, 16'd300, 16'd200, 16'd100};
      step(1'b1, 1'b1, 4'd5, 4'd2, 1'b0, 8'd3, 4'h0, dall);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'b0100, dall);
      idle(2);
      step(1'b1, 1'b1, 4'd5, 4'd3, 1'b0, 8'd4, 4'h0, dall);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'b0101, dall);
      idle(2);
      chk("fair_nwr", 32'(cap_data.size()), 32'd7);
      if (cap_data.size() == 7) begin
         for (int i = 0; i < 3; i++) chk("pe2_only", 32'(cap_data[i]), 32'd300);
         chk("fair_0", 32'(cap_data[3]), 32'd100);
         chk("fair_1", 32'(cap_data[4]), 32'd300);
         chk("fair_2", 32'(cap_data[5]), 32'd100);
         chk("fair_3", 32'(cap_data[6]), 32'd300);
      end

      // Reset after two of four transfers, then restart.
      clear_cap();
      dall = {16'd4, 16'd3, 16'd2, 16'd1};
      step(1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 8'd4, 4'h0, dall);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'hF, dall);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'hF, dall);
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'hF, dall);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'hF, dall);
      idle(2);
      chk("rstmid_nwr", 32'(cap_data.size()), 32'd2);
      clear_cap();
      step(1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 8'd2, 4'h0, dall);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'hF, dall);
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 4'hF, dall);
      idle(2);
      chk("restart_nwr", 32'(cap_data.size()), 32'd2);
      if (cap_data.size() == 2) begin
         chk("restart_addr", 32'(cap_addr[0]), 32'h7700);
         chk("restart_data", 32'(cap_data[0]), 32'd1);
      end

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
              4'($urandom), 4'($urandom), 1'($urandom),
              8'($urandom_range(0, 6)), 4'($urandom),
              {$urandom, $urandom});
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
